// File: rtl/decode_pkg.sv
// Shared definitions for the RISC-V field decode stage: opcodes, format
// classes, flag bit positions and the per-format base flag patterns.
package decode_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        INSTR_R       = 3'd0,
        INSTR_I       = 3'd1,
        INSTR_S       = 3'd2,
        INSTR_SB      = 3'd3,
        INSTR_U       = 3'd4,
        INSTR_UJ      = 3'd5,
        INSTR_ILLEGAL = 3'd6
    } instr_type_e;

    // Flag byte bit positions
    localparam int WRITES_RD     = 0;
    localparam int READS_RS1     = 1;
    localparam int READS_RS2     = 2;
    localparam int USES_IMM      = 3;
    localparam int IS_DIFF_INDEX = 4;
    localparam int ILLEGAL       = 5;

    // Base patterns, ordered {uses_imm, reads_rs2, reads_rs1, writes_rd}
    localparam logic [3:0] BASE_R       = 4'b0111;
    localparam logic [3:0] BASE_I       = 4'b1011;
    localparam logic [3:0] BASE_S       = 4'b1110;
    localparam logic [3:0] BASE_SB      = 4'b1110;
    localparam logic [3:0] BASE_U       = 4'b1001;
    localparam logic [3:0] BASE_UJ      = 4'b1001;
    localparam logic [3:0] BASE_ILLEGAL = 4'b0000;

    function automatic logic [3:0] base_flags(input instr_type_e t);
        logic [3:0] f;
        case (t)
            INSTR_R:  f = BASE_R;
            INSTR_I:  f = BASE_I;
            INSTR_S:  f = BASE_S;
            INSTR_SB: f = BASE_SB;
            INSTR_U:  f = BASE_U;
            INSTR_UJ: f = BASE_UJ;
            default:  f = BASE_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction decoder: format class, register numbers,
// sign-extended immediate and flag byte. An invalid lane decodes to all zeros.
module decode_lane
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int RW   = 5,
    parameter int FW   = 8
) (
    input  logic            lane_valid,
    input  logic [ILEN-1:0] instr,
    input  logic [FW-1:0]   flag_in,
    output logic [RW-1:0]   rd,
    output logic [RW-1:0]   rs1,
    output logic [RW-1:0]   rs2,
    output logic [XLEN-1:0] imm,
    output logic [FW-1:0]   flag
);

    localparam bit IS_RV64 = (XLEN == 64);

    instr_type_e itype_s;
    logic [63:0] imm64_s;
    logic [3:0]  masked_s;
    logic        unused_s;

    // Word-only opcodes and funct3 do not influence field extraction
    assign unused_s = ^{instr, flag_in, imm64_s};

    // Classify the instruction format from the opcode
    always_comb begin
        itype_s = INSTR_ILLEGAL;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:                          itype_s = INSTR_U;
            OPC_JAL:                                     itype_s = INSTR_UJ;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM:  itype_s = INSTR_I;
            OPC_OP_IMM_32: itype_s = IS_RV64 ? INSTR_I : INSTR_ILLEGAL;
            OPC_BRANCH:                                  itype_s = INSTR_SB;
            OPC_STORE:                                   itype_s = INSTR_S;
            OPC_OP:                                      itype_s = INSTR_R;
            OPC_OP_32:     itype_s = IS_RV64 ? INSTR_R : INSTR_ILLEGAL;
            default:                                     itype_s = INSTR_ILLEGAL;
        endcase
    end

    // Assemble the immediate at 64 bits, narrowed to XLEN at the output
    always_comb begin
        imm64_s = 64'd0;
        case (itype_s)
            INSTR_I:  imm64_s = {{52{instr[31]}}, instr[31:20]};
            INSTR_S:  imm64_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            INSTR_SB: imm64_s = {{51{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
            INSTR_U:  imm64_s = {{32{instr[31]}}, instr[31:12], 12'd0};
            INSTR_UJ: imm64_s = {{43{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
            default:  imm64_s = 64'd0;
        endcase
    end

    // Combine base pattern with optional upstream mask
    always_comb begin
        masked_s = flag_in[IS_DIFF_INDEX] ? (base_flags(itype_s) & flag_in[3:0])
                                          : base_flags(itype_s);
    end

    // Drive lane outputs; an empty slot carries zeros
    always_comb begin
        rd   = '0;
        rs1  = '0;
        rs2  = '0;
        imm  = '0;
        flag = '0;
        if (lane_valid) begin
            rd                  = instr[11:7];
            rs1                 = instr[19:15];
            rs2                 = instr[24:20];
            imm                 = imm64_s[XLEN-1:0];
            flag[3:0]           = masked_s;
            flag[WRITES_RD]     = masked_s[WRITES_RD] & (instr[11:7] != 5'd0);
            flag[IS_DIFF_INDEX] = flag_in[IS_DIFF_INDEX];
            flag[ILLEGAL]       = (itype_s == INSTR_ILLEGAL);
        end else begin
            rd   = '0;
            rs1  = '0;
            rs2  = '0;
            imm  = '0;
            flag = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered multi-lane decode stage with a small in-order output buffer.
// Slot 0 of the buffer is always the head and drives the outputs directly;
// slots at or beyond the fill count are kept at zero.
module decode_stage
    import decode_pkg::*;
#(
    parameter int ISSUE_WIDTH        = 2,
    parameter int XLEN               = 32,
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int REGISTER_WIDTH     = 5,
    parameter int FLAG_WIDTH         = 8,
    parameter int BUF_DEPTH          = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ISSUE_WIDTH-1:0]                 in_lane_valid,
    input  logic [ISSUE_WIDTH*INSTRUCTION_LENGTH-1:0] in_instr,
    input  logic [ISSUE_WIDTH*FLAG_WIDTH-1:0]      in_flag,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ISSUE_WIDTH-1:0]                 out_lane_valid,
    output logic [ISSUE_WIDTH*REGISTER_WIDTH-1:0]  out_rd,
    output logic [ISSUE_WIDTH*REGISTER_WIDTH-1:0]  out_rs1,
    output logic [ISSUE_WIDTH*REGISTER_WIDTH-1:0]  out_rs2,
    output logic [ISSUE_WIDTH*XLEN-1:0]            out_imm,
    output logic [ISSUE_WIDTH*FLAG_WIDTH-1:0]      out_flag
);

    localparam int IW = ISSUE_WIDTH;
    localparam int RW = REGISTER_WIDTH;
    localparam int FW = FLAG_WIDTH;
    localparam int IL = INSTRUCTION_LENGTH;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [IW-1:0]      lv;
        logic [IW*RW-1:0]   rd;
        logic [IW*RW-1:0]   rs1;
        logic [IW*RW-1:0]   rs2;
        logic [IW*XLEN-1:0] imm;
        logic [IW*FW-1:0]   flag;
    } entry_t;

    logic [IW*RW-1:0]   dec_rd_s;
    logic [IW*RW-1:0]   dec_rs1_s;
    logic [IW*RW-1:0]   dec_rs2_s;
    logic [IW*XLEN-1:0] dec_imm_s;
    logic [IW*FW-1:0]   dec_flag_s;
    entry_t             new_entry_s;

    entry_t             buf_q     [BUF_DEPTH];
    entry_t             buf_d     [BUF_DEPTH];
    entry_t             shifted_s [BUF_DEPTH];
    logic [CW-1:0]      count_q, count_d, cnt_after_s;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               push_s, pop_s;

    for (genvar g = 0; g < IW; g++) begin : g_lane
        decode_lane #(
            .XLEN (XLEN),
            .ILEN (IL),
            .RW   (RW),
            .FW   (FW)
        ) u_lane (
            .lane_valid (in_lane_valid[g]),
            .instr      (in_instr[g*IL +: IL]),
            .flag_in    (in_flag[g*FW +: FW]),
            .rd         (dec_rd_s[g*RW +: RW]),
            .rs1        (dec_rs1_s[g*RW +: RW]),
            .rs2        (dec_rs2_s[g*RW +: RW]),
            .imm        (dec_imm_s[g*XLEN +: XLEN]),
            .flag       (dec_flag_s[g*FW +: FW])
        );
    end

    assign push_s = in_valid & in_ready_q;
    assign pop_s  = out_valid_q & out_ready;

    // Gather the decoded lanes into one buffer entry
    always_comb begin
        new_entry_s.lv   = in_lane_valid;
        new_entry_s.rd   = dec_rd_s;
        new_entry_s.rs1  = dec_rs1_s;
        new_entry_s.rs2  = dec_rs2_s;
        new_entry_s.imm  = dec_imm_s;
        new_entry_s.flag = dec_flag_s;
    end

    // Advance the buffer on a pop, zero-filling the vacated tail slot
    always_comb begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (i == BUF_DEPTH - 1) begin
                shifted_s[i] = pop_s ? '0 : buf_q[i];
            end else begin
                shifted_s[i] = pop_s ? buf_q[i+1] : buf_q[i];
            end
        end
    end

    // Write the new beat behind the surviving entries and update status
    always_comb begin
        cnt_after_s = count_q - CW'(pop_s);
        for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_d[i] = (push_s && (CW'(i) == cnt_after_s)) ? new_entry_s : shifted_s[i];
        end
        count_d     = cnt_after_s + CW'(push_s);
        out_valid_d = (count_d != '0);
        in_ready_d  = (count_d < CW'(BUF_DEPTH));
    end

    // Buffer, fill count and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_lane_valid = buf_q[0].lv;
    assign out_rd         = buf_q[0].rd;
    assign out_rs1        = buf_q[0].rs1;
    assign out_rs2        = buf_q[0].rs2;
    assign out_imm        = buf_q[0].imm;
    assign out_flag       = buf_q[0].flag;

endmodule
